// File: rtl/fat_seq_if.sv
// ---------------------------------------------------------------------------
// fat_seq_if
// Command handshake between the FAT chain sequencer and the SD command engine.
//
// Signals
//   cmdreq  : sequencer requests a command (held until cmdack is seen)
//   cmdack  : command engine accepted the pending command
//   CMDIDX  : 6-bit command index (17 = single read, 24 = single write)
//   CMDARG  : 32-bit command argument (sector LBA)
//
// Modports
//   master  : the sequencer side (drives request, index and argument)
//   slave   : the command engine side (drives the acknowledge)
// ---------------------------------------------------------------------------
interface fat_seq_if;
  logic        cmdreq;
  logic        cmdack;
  logic [5:0]  CMDIDX;
  logic [31:0] CMDARG;

  modport master (
    output cmdreq,
    output CMDIDX,
    output CMDARG,
    input  cmdack
  );

  modport slave (
    input  cmdreq,
    input  CMDIDX,
    input  CMDARG,
    output cmdack
  );
endinterface

// File: rtl/fat_seq.sv
// ---------------------------------------------------------------------------
// fat_seq
// Sequencer that extends a FAT cluster chain: it reads FAT sectors until the
// end marker is located, lets the FAT controller patch the sector buffer,
// then writes the sector back to FAT1 and FAT2, repeating until the
// end-of-chain has been written in both copies.
//
// Optional feature (compile-time macro FATSEQ_TIMEOUT_EN):
//   defined   : a TOUT_W-bit watchdog sends the FSM to ERR if RD_DAT, WR_DAT
//               or WR_ACK last TOUT_MAX cycles.
//   undefined : no watchdog; those states wait indefinitely.
//
// Ports
//   clk, nreset       : clock, asynchronous active-low reset
//   start             : request to extend the chain (only seen in IDLE)
//   cmd (master)      : cmdreq/cmdack/CMDIDX/CMDARG command handshake
//   tcvdptdone        : one-cycle DAT packet transfer complete pulse
//   lwe               : DAT line not busy
//   isfatend          : end marker not yet found in the current sector
//   fatp1done         : sector buffer modification pass complete
//   isfat2            : current write target is FAT2
//   eoff              : end-of-chain written in both FAT copies
//   FATBASE, FATSIZE  : FAT1 first LBA, sectors per FAT copy
//   FATSACNTR         : FAT sector offset from the FAT controller
//   frprmen, fsprmp1en, fwprm, fsprmp2en, fwacken : FAT controller enables
//   done              : one-cycle completion pulse
//   err               : sticky failure flag (cleared only by nreset)
// ---------------------------------------------------------------------------
module fat_seq #(
  parameter int unsigned         TOUT_W   = 20,
  parameter logic [TOUT_W-1:0]   TOUT_MAX = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  fat_seq_if.master   cmd,
  input  logic        tcvdptdone,
  input  logic        lwe,
  input  logic        isfatend,
  input  logic        fatp1done,
  input  logic        isfat2,
  input  logic        eoff,
  input  logic [31:0] FATBASE,
  input  logic [31:0] FATSIZE,
  input  logic [15:0] FATSACNTR,
  output logic        frprmen,
  output logic        fsprmp1en,
  output logic        fwprm,
  output logic        fsprmp2en,
  output logic        fwacken,
  output logic        done,
  output logic        err
);

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_RD_CMD = 4'd1;
  localparam logic [3:0] ST_RD_DAT = 4'd2;
  localparam logic [3:0] ST_SET_P1 = 4'd3;
  localparam logic [3:0] ST_WR_CMD = 4'd4;
  localparam logic [3:0] ST_WR_DAT = 4'd5;
  localparam logic [3:0] ST_WR_ACK = 4'd6;
  localparam logic [3:0] ST_SET_P2 = 4'd7;
  localparam logic [3:0] ST_DONE   = 4'd8;
  localparam logic [3:0] ST_ERR    = 4'd9;

  logic [3:0]  state_q, state_d;
  logic [31:0] rdcnt_q, rdcnt_d;
  logic [31:0] cmdarg_q, cmdarg_d;
  logic [31:0] rd_lba;
  logic [31:0] wr_lba;
  logic [31:0] rdcnt_inc;

  // Empty sanity blocks keep both watchdog parameters elaborated in every
  // build; a zero width shows up as a named block in the hierarchy.
  if (TOUT_W < 1) begin : g_bad_tout_w
  end
  if (TOUT_MAX == '0) begin : g_zero_tout_max
  end

`ifdef FATSEQ_TIMEOUT_EN
  logic [TOUT_W-1:0] tout_q, tout_d;
  logic [TOUT_W-1:0] tout_inc;
  logic              timed_q, timed_d;
`endif

  // Sector addresses. The argument is captured on entry to a command state
  // so that it cannot move while cmdreq is waiting for cmdack, even if the
  // FAT controller changes FATSACNTR or isfat2 in the meantime.
  always_comb begin
    rd_lba    = FATBASE + {16'h0000, FATSACNTR};
    wr_lba    = rd_lba + (isfat2 ? FATSIZE : 32'h0);
    rdcnt_inc = rdcnt_q + 32'd1;
  end

  // Next-state logic. The read counter only advances on a completed read
  // packet; running out of FAT sectors without finding the end marker is
  // the sequencing failure that leads to ERR.
  always_comb begin
    state_d = state_q;
    rdcnt_d = rdcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD_CMD;
          rdcnt_d = 32'h0;
        end
      end
      ST_RD_CMD: begin
        if (cmd.cmdack) state_d = ST_RD_DAT;
      end
      ST_RD_DAT: begin
        if (tcvdptdone) begin
          rdcnt_d = rdcnt_inc;
          if (!isfatend)                 state_d = ST_SET_P1;
          else if (rdcnt_inc == FATSIZE) state_d = ST_ERR;
          else                           state_d = ST_RD_CMD;
        end
      end
      ST_SET_P1: begin
        if (fatp1done) state_d = ST_WR_CMD;
      end
      ST_WR_CMD: begin
        if (cmd.cmdack) state_d = ST_WR_DAT;
      end
      ST_WR_DAT: begin
        if (tcvdptdone) state_d = ST_WR_ACK;
      end
      ST_WR_ACK: begin
        if (lwe) state_d = ST_SET_P2;
      end
      ST_SET_P2: begin
        if (eoff)        state_d = ST_DONE;
        else if (isfat2) state_d = ST_WR_CMD;
        else             state_d = ST_SET_P1;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase

`ifdef FATSEQ_TIMEOUT_EN
    // A state that would otherwise keep waiting gives up once the watchdog
    // reaches its limit; a real transition in the same cycle wins.
    if (timed_q && (state_d == state_q) && (tout_inc == TOUT_MAX)) begin
      state_d = ST_ERR;
    end
`endif
  end

  // Command argument register: loaded on entry to RD_CMD/WR_CMD, held while
  // the command is pending, zero everywhere else.
  always_comb begin
    cmdarg_d = 32'h0;
    if (state_d == ST_RD_CMD) begin
      cmdarg_d = (state_q == ST_RD_CMD) ? cmdarg_q : rd_lba;
    end else if (state_d == ST_WR_CMD) begin
      cmdarg_d = (state_q == ST_WR_CMD) ? cmdarg_q : wr_lba;
    end
  end

`ifdef FATSEQ_TIMEOUT_EN
  // Watchdog: restarts from zero whenever a watched state is entered and
  // counts every cycle spent there.
  always_comb begin
    tout_inc = tout_q + {{(TOUT_W-1){1'b0}}, 1'b1};
    timed_q  = (state_q == ST_RD_DAT) || (state_q == ST_WR_DAT) ||
               (state_q == ST_WR_ACK);
    timed_d  = (state_d == ST_RD_DAT) || (state_d == ST_WR_DAT) ||
               (state_d == ST_WR_ACK);
    tout_d   = '0;
    if (timed_d && (state_d == state_q)) begin
      tout_d = tout_inc;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) tout_q <= '0;
    else         tout_q <= tout_d;
  end
`endif

  // State, read counter and captured command argument.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_IDLE;
      rdcnt_q  <= 32'h0;
      cmdarg_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      rdcnt_q  <= rdcnt_d;
      cmdarg_q <= cmdarg_d;
    end
  end

  // Outputs decode straight from the registered state, so reset (IDLE)
  // drives every one of them to zero without extra flops.
  always_comb begin
    frprmen    = (state_q == ST_RD_DAT);
    fsprmp1en  = (state_q == ST_SET_P1);
    fwprm      = (state_q == ST_WR_DAT);
    fsprmp2en  = (state_q == ST_SET_P2);
    fwacken    = (state_q == ST_WR_ACK);
    done       = (state_q == ST_DONE);
    err        = (state_q == ST_ERR);
    cmd.cmdreq = (state_q == ST_RD_CMD) || (state_q == ST_WR_CMD);
    cmd.CMDARG = cmdarg_q;
    cmd.CMDIDX = 6'd0;
    if (state_q == ST_RD_CMD) cmd.CMDIDX = 6'd17;
    if (state_q == ST_WR_CMD) cmd.CMDIDX = 6'd24;
  end

endmodule

// File: tb/tb_fat_seq.sv
// ---------------------------------------------------------------------------
// tb_fat_seq
// Directed bench for fat_seq: a table of single-cycle vectors walks one full
// FAT1+FAT2 chain update, followed by hand-written sequences for the
// sector-exhaustion error, the FAT1-only loop back, reset during WR_ACK and
// the WR_ACK watchdog (behaviour depends on FATSEQ_TIMEOUT_EN).
// ---------------------------------------------------------------------------
module tb_fat_seq;

  // Input bits packed as {start, cmdack, tcvdptdone, lwe, isfatend,
  // fatp1done, isfat2, eoff}.
  localparam logic [7:0] I_NONE = 8'h00;
  localparam logic [7:0] I_S    = 8'h80;
  localparam logic [7:0] I_A    = 8'h40;
  localparam logic [7:0] I_T    = 8'h20;
  localparam logic [7:0] I_L    = 8'h10;
  localparam logic [7:0] I_E    = 8'h08;
  localparam logic [7:0] I_P    = 8'h04;
  localparam logic [7:0] I_F2   = 8'h02;
  localparam logic [7:0] I_EO   = 8'h01;

  // Enables packed as {frprmen, fsprmp1en, fwprm, fsprmp2en, fwacken}.
  localparam logic [4:0] EN_NO  = 5'b00000;
  localparam logic [4:0] EN_RD  = 5'b10000;
  localparam logic [4:0] EN_P1  = 5'b01000;
  localparam logic [4:0] EN_WD  = 5'b00100;
  localparam logic [4:0] EN_P2  = 5'b00010;
  localparam logic [4:0] EN_ACK = 5'b00001;

  typedef struct {
    string       name;
    logic [7:0]  stim;
    logic [45:0] expect_out;
  } vec_t;

  logic        clk;
  logic        nreset;
  logic        start;
  logic        tcvdptdone;
  logic        lwe;
  logic        isfatend;
  logic        fatp1done;
  logic        isfat2;
  logic        eoff;
  logic [31:0] fat_base;
  logic [31:0] fat_size;
  logic [15:0] fat_sacntr;
  logic        frprmen;
  logic        fsprmp1en;
  logic        fwprm;
  logic        fsprmp2en;
  logic        fwacken;
  logic        done;
  logic        err;

  int total_cnt;
  int bad_cnt;

  vec_t vecs[18];

  fat_seq_if cmd_bus ();

  fat_seq #(
    .TOUT_W   (20),
    .TOUT_MAX (20'd16)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .start      (start),
    .cmd        (cmd_bus),
    .tcvdptdone (tcvdptdone),
    .lwe        (lwe),
    .isfatend   (isfatend),
    .fatp1done  (fatp1done),
    .isfat2     (isfat2),
    .eoff       (eoff),
    .FATBASE    (fat_base),
    .FATSIZE    (fat_size),
    .FATSACNTR  (fat_sacntr),
    .frprmen    (frprmen),
    .fsprmp1en  (fsprmp1en),
    .fwprm      (fwprm),
    .fsprmp2en  (fsprmp2en),
    .fwacken    (fwacken),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word {enables, cmdreq, CMDIDX, CMDARG, done, err}.
  function automatic logic [45:0] exp_out(input logic [4:0] en, input logic req,
                                          input logic [5:0] idx, input logic [31:0] arg,
                                          input logic dn, input logic er);
    return {en, req, idx, arg, dn, er};
  endfunction

  function automatic vec_t mk(input string nm, input logic [7:0] stim,
                              input logic [45:0] e);
    vec_t v;
    v.name       = nm;
    v.stim       = stim;
    v.expect_out = e;
    return v;
  endfunction

  task automatic drive_inputs(input logic [7:0] stim);
    {start, cmd_bus.cmdack, tcvdptdone, lwe, isfatend, fatp1done, isfat2, eoff} = stim;
  endtask

  // Drive one cycle of inputs, let the rising edge take them, then sample
  // 2 ns later.
  task automatic apply_stimulus(input logic [7:0] stim);
    drive_inputs(stim);
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string nm, input logic [45:0] e);
    logic [45:0] act;
    act = {frprmen, fsprmp1en, fwprm, fsprmp2en, fwacken,
           cmd_bus.cmdreq, cmd_bus.CMDIDX, cmd_bus.CMDARG, done, err};
    total_cnt++;
    if (act !== e) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got en=%b req=%b idx=%0d arg=%h done=%b err=%b, want en=%b req=%b idx=%0d arg=%h done=%b err=%b",
               nm, act[45:41], act[40], act[39:34], act[33:2], act[1], act[0],
               e[45:41], e[40], e[39:34], e[33:2], e[1], e[0]);
    end
  endtask

  task automatic do_reset(input string nm);
    drive_inputs(I_NONE);
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_output(nm, exp_out(EN_NO, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0));
    nreset = 1'b1;
  endtask

  // Walks from IDLE to WR_ACK of the FAT1 write with the marker in the first
  // packet; uses the current FATBASE/FATSACNTR values.
  task automatic go_to_wr_ack();
    apply_stimulus(I_S);
    apply_stimulus(I_A);
    apply_stimulus(I_T);
    apply_stimulus(I_P);
    apply_stimulus(I_A);
    apply_stimulus(I_T);
  endtask

  initial begin
    total_cnt  = 0;
    bad_cnt    = 0;
    nreset     = 1'b0;
    fat_base   = 32'h0000_0800;
    fat_size   = 32'h0000_0100;
    fat_sacntr = 16'd3;
    drive_inputs(I_NONE);

    $display("[TB] starting fat_seq bench");
    do_reset("reset_state");

    // Full chain update: read, patch, FAT1 write, FAT2 write, done.
    vecs[0]  = mk("start_cmd17",     I_S,       exp_out(EN_NO,  1'b1, 6'd17, 32'h803, 1'b0, 1'b0));
    vecs[1]  = mk("cmd17_hold",      I_NONE,    exp_out(EN_NO,  1'b1, 6'd17, 32'h803, 1'b0, 1'b0));
    vecs[2]  = mk("rd_dat",          I_A,       exp_out(EN_RD,  1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[3]  = mk("rd_dat_start_ign",I_S,       exp_out(EN_RD,  1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[4]  = mk("marker_to_p1",    I_T,       exp_out(EN_P1,  1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[5]  = mk("p1_wait",         I_T,       exp_out(EN_P1,  1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[6]  = mk("wr1_cmd24",       I_P,       exp_out(EN_NO,  1'b1, 6'd24, 32'h803, 1'b0, 1'b0));
    vecs[7]  = mk("wr1_dat",         I_A,       exp_out(EN_WD,  1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[8]  = mk("wr1_ack",         I_T,       exp_out(EN_ACK, 1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[9]  = mk("wr1_ack_busy",    I_NONE,    exp_out(EN_ACK, 1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[10] = mk("wr1_p2",          I_L,       exp_out(EN_P2,  1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[11] = mk("wr2_cmd24",       I_F2,      exp_out(EN_NO,  1'b1, 6'd24, 32'h903, 1'b0, 1'b0));
    vecs[12] = mk("wr2_dat",         I_A|I_F2,  exp_out(EN_WD,  1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[13] = mk("wr2_ack",         I_T|I_F2,  exp_out(EN_ACK, 1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[14] = mk("wr2_p2",          I_L|I_F2,  exp_out(EN_P2,  1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[15] = mk("done_pulse",      I_EO|I_F2, exp_out(EN_NO,  1'b0, 6'd0,  32'h0,   1'b1, 1'b0));
    vecs[16] = mk("back_idle",       I_NONE,    exp_out(EN_NO,  1'b0, 6'd0,  32'h0,   1'b0, 1'b0));
    vecs[17] = mk("idle_stays",      I_T,       exp_out(EN_NO,  1'b0, 6'd0,  32'h0,   1'b0, 1'b0));

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i].stim);
      check_output(vecs[i].name, vecs[i].expect_out);
    end

    // Marker never found in a 2-sector FAT: two reads, then sticky error.
    do_reset("reset_before_exhaust");
    fat_size   = 32'd2;
    fat_sacntr = 16'd5;
    apply_stimulus(I_S);
    check_output("exh_rd1_cmd", exp_out(EN_NO, 1'b1, 6'd17, 32'h805, 1'b0, 1'b0));
    apply_stimulus(I_A);
    apply_stimulus(I_T|I_E);
    check_output("exh_rd2_cmd", exp_out(EN_NO, 1'b1, 6'd17, 32'h805, 1'b0, 1'b0));
    apply_stimulus(I_A);
    check_output("exh_rd2_dat", exp_out(EN_RD, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0));
    apply_stimulus(I_T|I_E);
    check_output("exh_err", exp_out(EN_NO, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1));
    apply_stimulus(I_S|I_A|I_T|I_L|I_P);
    check_output("err_sticky", exp_out(EN_NO, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1));

    // FAT1+FAT2 written without eoff, then isfat2=0 loops to the next sector
    // whose write address follows the updated FATSACNTR.
    do_reset("reset_before_loop");
    fat_size   = 32'h100;
    fat_sacntr = 16'd3;
    apply_stimulus(I_S);
    apply_stimulus(I_A);
    apply_stimulus(I_T);
    apply_stimulus(I_P);
    check_output("loop_wr1_arg", exp_out(EN_NO, 1'b1, 6'd24, 32'h803, 1'b0, 1'b0));
    apply_stimulus(I_A);
    apply_stimulus(I_T);
    apply_stimulus(I_L);
    apply_stimulus(I_F2);
    check_output("loop_wr2_arg", exp_out(EN_NO, 1'b1, 6'd24, 32'h903, 1'b0, 1'b0));
    apply_stimulus(I_A);
    apply_stimulus(I_T);
    apply_stimulus(I_L);
    apply_stimulus(I_NONE);
    check_output("loop_back_p1", exp_out(EN_P1, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0));
    fat_sacntr = 16'd4;
    apply_stimulus(I_P);
    check_output("loop_next_arg", exp_out(EN_NO, 1'b1, 6'd24, 32'h804, 1'b0, 1'b0));

    // Asynchronous reset in the middle of WR_ACK, no clock edge involved.
    do_reset("reset_before_async");
    fat_sacntr = 16'd3;
    go_to_wr_ack();
    check_output("async_in_wr_ack", exp_out(EN_ACK, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0));
    #1 nreset = 1'b0;
    #1;
    check_output("async_cleared", exp_out(EN_NO, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0));
    #1 nreset = 1'b1;
    apply_stimulus(I_S);
    check_output("after_async_cmd17", exp_out(EN_NO, 1'b1, 6'd17, 32'h803, 1'b0, 1'b0));

    // DAT line stuck busy in WR_ACK.
    do_reset("reset_before_wdog");
    go_to_wr_ack();
    for (int i = 0; i < 15; i++) apply_stimulus(I_NONE);
    check_output("wdog_15_cycles", exp_out(EN_ACK, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0));
    apply_stimulus(I_NONE);
`ifdef FATSEQ_TIMEOUT_EN
    check_output("wdog_trip", exp_out(EN_NO, 1'b0, 6'd0, 32'h0, 1'b0, 1'b1));
`else
    for (int i = 0; i < 8; i++) apply_stimulus(I_NONE);
    check_output("no_wdog_waits", exp_out(EN_ACK, 1'b0, 6'd0, 32'h0, 1'b0, 1'b0));
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
